// File: rtl/hslp_mul_pipe.sv
// hslp_mul_pipe: pipelined hybrid split-level approximate multiplier.
//
// The W-bit unsigned operands are split into H = W/2 bit halves. Four
// quadrant products (HH, HL, LH, LL) are formed. Each quadrant has its own
// 2-bit accuracy mode, taken from cfg_mode with the beat:
//   0 exact, 1 low H/2 bits cleared, 2 low H bits cleared, 3 quadrant skipped.
// The moded quadrants are then recombined by shift-add.
//
// Pipeline:
//   S1 captures the operands and the mode.
//   S2 captures the four moded quadrant products.
//   S3 captures the recombined product.
// The stream interface is valid/ready with full backpressure and accepts
// one beat per cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand beat handshake (a, b, cfg_mode)
//   a, b                W-bit unsigned operands
//   cfg_mode            [1:0]=LL [3:2]=LH [5:4]=HL [7:6]=HH accuracy modes
//   out_valid/out_ready result handshake
//   prod                2W-bit approximate product
module hslp_mul_pipe #(
  parameter int unsigned W       = 8,
  parameter int unsigned OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [7:0]       cfg_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   prod
);

  localparam int unsigned H = W / 2;
  localparam int unsigned P = 2 * H;

  localparam logic [P-1:0] MASK_COARSE = {P{1'b1}} << (H / 2);
  localparam logic [P-1:0] MASK_HALF   = {P{1'b1}} << H;

  if (OUT_REG != 1) begin : g_out_reg_unsupported
    $error("hslp_mul_pipe: only OUT_REG=1 is supported");
  end

  function automatic logic [P-1:0] apply_mode(input logic [P-1:0] p,
                                              input logic [1:0]   m);
    logic [P-1:0] r;
    unique case (m)
      2'd0:    r = p;
      2'd1:    r = p & MASK_COARSE;
      2'd2:    r = p & MASK_HALF;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic             stall;

  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  logic [7:0]       s1_mode_q, s1_mode_d;

  logic             s2_valid_q, s2_valid_d;
  logic [P-1:0]     s2_hh_q, s2_hh_d;
  logic [P-1:0]     s2_hl_q, s2_hl_d;
  logic [P-1:0]     s2_lh_q, s2_lh_d;
  logic [P-1:0]     s2_ll_q, s2_ll_d;

  logic             out_valid_q, out_valid_d;
  logic [2*W-1:0]   prod_q, prod_d;

  logic [H-1:0]     ah, al, bh, bl;
  logic [2*W-1:0]   sum;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign prod      = prod_q;

  assign ah = s1_a_q[W-1:H];
  assign al = s1_a_q[H-1:0];
  assign bh = s1_b_q[W-1:H];
  assign bl = s1_b_q[H-1:0];

  // The exact product fits in 2W bits and modes only ever lower terms, so
  // summing at 2W bits loses nothing relative to a wider sum.
  always_comb begin
    sum = (2*W)'(s2_ll_q)
        + ((2*W)'(s2_lh_q) << H)
        + ((2*W)'(s2_hl_q) << H)
        + ((2*W)'(s2_hh_q) << W);
  end

  // Every stage holds on stall. Data registers also hold across bubbles,
  // so prod keeps its last value instead of toggling.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_mode_d   = s1_mode_q;
    s2_valid_d  = s2_valid_q;
    s2_hh_d     = s2_hh_q;
    s2_hl_d     = s2_hl_q;
    s2_lh_d     = s2_lh_q;
    s2_ll_d     = s2_ll_q;
    out_valid_d = out_valid_q;
    prod_d      = prod_q;
    if (!stall) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d    = a;
        s1_b_d    = b;
        s1_mode_d = cfg_mode;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_ll_d = apply_mode(P'(al) * P'(bl), s1_mode_q[1:0]);
        s2_lh_d = apply_mode(P'(al) * P'(bh), s1_mode_q[3:2]);
        s2_hl_d = apply_mode(P'(ah) * P'(bl), s1_mode_q[5:4]);
        s2_hh_d = apply_mode(P'(ah) * P'(bh), s1_mode_q[7:6]);
      end
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        prod_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_hh_q     <= '0;
      s2_hl_q     <= '0;
      s2_lh_q     <= '0;
      s2_ll_q     <= '0;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      s2_valid_q  <= s2_valid_d;
      s2_hh_q     <= s2_hh_d;
      s2_hl_q     <= s2_hl_d;
      s2_lh_q     <= s2_lh_d;
      s2_ll_q     <= s2_ll_d;
      out_valid_q <= out_valid_d;
      prod_q      <= prod_d;
    end
  end

endmodule

// File: tb/tb_hslp_mul_pipe.sv
// tb_hslp_mul_pipe: self-checking bench for hslp_mul_pipe (W=8).
// A negedge monitor keeps a queue of expected products. The queue is built
// from an arithmetic reference model and is checked in order against every
// consumed result. The monitor also checks that the output holds while stalled.
module tb_hslp_mul_pipe;

  localparam int unsigned W = 8;
  localparam int unsigned H = W / 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [7:0]       cfg_mode;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   prod;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_out  = 0;

  longint unsigned exp_q[$];
  bit              prev_stall = 1'b0;
  logic [2*W-1:0]  prev_prod  = '0;

  hslp_mul_pipe #(.W(W), .OUT_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cfg_mode  (cfg_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned quad(input longint unsigned p, input int unsigned m);
    longint unsigned q1 = longint'(2) ** (H / 2);
    longint unsigned q2 = longint'(2) ** H;
    case (m)
      0:       return p;
      1:       return (p / q1) * q1;
      2:       return (p / q2) * q2;
      default: return 0;
    endcase
  endfunction

  function automatic longint unsigned ref_prod(input int unsigned av, input int unsigned bv,
                                               input int unsigned mv);
    longint unsigned s   = longint'(2) ** H;
    longint unsigned ah  = av / s;
    longint unsigned al  = av % s;
    longint unsigned bh  = bv / s;
    longint unsigned bl  = bv % s;
    longint unsigned sum;
    sum = quad(al * bl, mv % 4)
        + (quad(al * bh, (mv / 4) % 4) + quad(ah * bl, (mv / 16) % 4)) * s
        + quad(ah * bh, (mv / 64) % 4) * s * s;
    return sum % (longint'(2) ** (2 * W));
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_out_valid", out_valid, 1);
        chk("hold_prod", prod, prev_prod);
      end
      if (out_valid && out_ready) begin
        chk("out_has_beat", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("prod", prod, exp_q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_prod(a, b, cfg_mode));
      prev_stall = out_valid && !out_ready;
      prev_prod  = prod;
    end
  end

  task automatic new_beat();
    a        = W'($urandom);
    b        = W'($urandom);
    cfg_mode = 8'($urandom);
  endtask

  task automatic run_stream(input int unsigned n, input bit rnd, output int unsigned cyc);
    int unsigned sent = 0;
    bit acc;
    cyc = 0;
    while (sent < n && cyc < n * 20 + 50) begin
      in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        new_beat();
      end
    end
    in_valid = 1'b0;
    chk("stream_sent", sent, n);
  endtask

  task automatic drain(input string tag);
    int unsigned c = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic one_shot(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [7:0] tm, input logic [2*W-1:0] exp_p,
                          input string tag);
    out_ready = 1'b1;
    a = ta; b = tb_v; cfg_mode = tm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    new_beat();
    chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, prod, exp_p);
    @(posedge clk); #1;
    chk({tag, "_done"}, out_valid, 0);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned n0;
    int unsigned acc_n;
    bit acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cfg_mode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_prod", prod, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    one_shot(8'hFF, 8'hFF, 8'h00, 16'd65025, "exact_max");
    one_shot(8'hF0, 8'hF0, 8'h40, 16'd57344, "hh_mode1");
    one_shot(8'hF0, 8'h0F, 8'h20, 16'd3584,  "hl_mode2");
    one_shot(8'h0F, 8'h0F, 8'h03, 16'd0,     "ll_skip");
    one_shot(8'hFF, 8'hFF, 8'hAA, 16'd64736, "all_mode2");
    one_shot(8'hFF, 8'hFF, 8'hFF, 16'd0,     "all_skip");

    // back-to-back stream: one result per cycle after the fill latency
    n0 = n_out;
    new_beat();
    run_stream(10, 1'b0, cyc);
    chk("b2b_cycles", cyc, 10);
    chk("b2b_out_mid", n_out - n0, 7);
    repeat (3) begin @(posedge clk); #1; end
    chk("b2b_out_all", n_out - n0, 10);
    drain("b2b");

    // backpressure: only three beats fit before in_ready drops
    n0 = n_out;
    acc_n = 0;
    out_ready = 1'b0;
    new_beat();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_n++;
        new_beat();
      end
    end
    chk("stall_accepted", acc_n, 3);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_no_out", n_out - n0, 0);
    run_stream(2, 1'b0, cyc);
    drain("stall");
    chk("stall_out_count", n_out - n0, 5);

    // reset with three beats in flight
    out_ready = 1'b1;
    new_beat();
    run_stream(3, 1'b0, cyc);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_prod", prod, 0);
    chk("midrst_in_ready", in_ready, 1);
    n0 = n_out;
    out_ready = 1'b1;
    new_beat();
    in_valid = 1'b1;
    @(negedge clk);
    chk("midrst_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("midrst_out_count", n_out - n0, 1);
    drain("midrst");

    // random traffic with bubbles and backpressure
    n0 = n_out;
    new_beat();
    run_stream(300, 1'b1, cyc);
    drain("rand");
    chk("rand_out_count", n_out - n0, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
